// File: rtl/sdram_ctrl_if.sv
// Host-side request/response bundle for sdram_ctrl: request strobe with
// command/address/data, and ready/read-data/completion back to the host.
interface sdram_ctrl_if #(
    parameter int width      = 8,
    parameter int addr_width = 8
);
    logic                  req;
    logic                  req_we;
    logic [addr_width-1:0] req_addr;
    logic [width-1:0]      req_wdata;
    logic                  ready;
    logic [width-1:0]      rd_data;
    logic                  rd_valid;
    logic                  wr_done;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  ready, rd_data, rd_valid, wr_done
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output ready, rd_data, rd_valid, wr_done
    );
endinterface

// File: rtl/sdram_ctrl.sv
// Single-transaction memory sequencer: WAIT, RAS and CAS phases of two cycles
// each, then a one-cycle DONE that reports read data or write completion.
module sdram_ctrl #(
    parameter int width      = 8,
    parameter int depth      = 256,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  reset,
    sdram_ctrl_if.slave           host,
    inout  wire  [width-1:0]      mem_data,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_cmd,
    output logic                  mem_seq,
    output logic                  mem_wait,
    output logic                  mem_ras,
    output logic                  mem_cas
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RAS,
        S_CAS,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic                  ph_reg, ph_next;
    logic                  cmd_reg;
    logic [addr_width-1:0] addr_reg;
    logic [width-1:0]      wdata_reg;
    logic [width-1:0]      rd_data_reg;
    logic                  accept;
    logic                  bus_drive;

    assign accept = host.req && (state_reg == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            ph_reg      <= 1'b0;
            cmd_reg     <= 1'b1;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            ph_reg    <= ph_next;
            if (accept) begin
                cmd_reg   <= ~host.req_we;
                addr_reg  <= host.req_addr;
                wdata_reg <= host.req_wdata;
            end
            // Read data is captured on the edge that ends the second CAS cycle.
            if (state_reg == S_CAS && ph_reg && cmd_reg)
                rd_data_reg <= mem_data;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ph_next       = ph_reg;
        host.ready    = 1'b0;
        host.rd_valid = 1'b0;
        host.wr_done  = 1'b0;
        mem_seq       = 1'b0;
        mem_wait      = 1'b0;
        mem_ras       = 1'b0;
        mem_cas       = 1'b0;
        bus_drive     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                host.ready = 1'b1;
                if (accept) begin
                    state_next = S_WAIT;
                    ph_next    = 1'b0;
                end
            end
            S_WAIT: begin
                mem_seq  = 1'b1;
                mem_wait = 1'b1;
                ph_next  = ~ph_reg;
                if (ph_reg) state_next = S_RAS;
            end
            S_RAS: begin
                mem_seq = 1'b1;
                mem_ras = 1'b1;
                ph_next = ~ph_reg;
                if (ph_reg) state_next = S_CAS;
            end
            S_CAS: begin
                mem_seq   = 1'b1;
                mem_cas   = 1'b1;
                bus_drive = ~cmd_reg;
                ph_next   = ~ph_reg;
                if (ph_reg) state_next = S_DONE;
            end
            S_DONE: begin
                host.rd_valid = cmd_reg;
                host.wr_done  = ~cmd_reg;
                state_next    = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                ph_next    = 1'b0;
            end
        endcase
    end

    assign host.rd_data = rd_data_reg;
    assign mem_addr     = addr_reg;
    assign mem_cmd      = cmd_reg;
    assign mem_data     = bus_drive ? wdata_reg : {width{1'bz}};
endmodule

// File: tb/tb_sdram_ctrl.sv
// Randomized bench for sdram_ctrl: a word-array memory responder on the bus
// and a host-level reference memory predicting every read result.
module tb_sdram_ctrl;
    logic       clk;
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_cmd, mem_seq, mem_wait, mem_ras, mem_cas;
    tri1  [7:0] mem_data;

    sdram_ctrl_if #(.width(8), .addr_width(8)) host_if ();

    sdram_ctrl #(.width(8), .depth(256), .addr_width(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (host_if),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .mem_cmd  (mem_cmd),
        .mem_seq  (mem_seq),
        .mem_wait (mem_wait),
        .mem_ras  (mem_ras),
        .mem_cas  (mem_cas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: answers reads during CAS, stores write data on CAS edges.
    logic [7:0] dev_mem [256];
    logic       resp_en;
    assign resp_en  = mem_cas && mem_cmd;
    assign mem_data = resp_en ? dev_mem[mem_addr] : 8'hzz;
    always @(posedge clk)
        if (mem_cas && !mem_cmd) dev_mem[mem_addr] <= mem_data;

    logic [7:0] ref_mem [256];
    logic [7:0] last_rd;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {seq,wait,ras,cas} for cycle n after the acceptance edge.
    function automatic logic [3:0] exp_strobes(input int n);
        if (n == 1 || n == 2) return 4'b1100;
        if (n == 3 || n == 4) return 4'b1010;
        if (n == 5 || n == 6) return 4'b1001;
        return 4'b0000;
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (host_if.ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", {31'd0, host_if.ready}, 32'd1);
    endtask

    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic scramble);
        logic [7:0] exp_rd;
        logic [7:0] prev_rd;
        wait_ready();
        host_if.req       = 1'b1;
        host_if.req_we    = we;
        host_if.req_addr  = addr;
        host_if.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        host_if.req = 1'b0;
        prev_rd = last_rd;
        exp_rd  = we ? last_rd : ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        for (int n = 1; n <= 8; n++) begin
            if (scramble && n <= 6) begin
                host_if.req       = 1'($urandom_range(0, 1));
                host_if.req_we    = 1'($urandom_range(0, 1));
                host_if.req_addr  = 8'($urandom);
                host_if.req_wdata = 8'($urandom);
            end else begin
                host_if.req = 1'b0;
            end
            check("strobes", {28'd0, mem_seq, mem_wait, mem_ras, mem_cas}, {28'd0, exp_strobes(n)});
            check("ready", {31'd0, host_if.ready}, {31'd0, n == 8});
            check("rd_valid", {31'd0, host_if.rd_valid}, {31'd0, (n == 7) && !we});
            check("wr_done", {31'd0, host_if.wr_done}, {31'd0, (n == 7) && we});
            check("rd_data", {24'd0, host_if.rd_data}, {24'd0, (n >= 7) ? exp_rd : prev_rd});
            if (n <= 7) begin
                check("mem_addr", {24'd0, mem_addr}, {24'd0, addr});
                check("mem_cmd", {31'd0, mem_cmd}, {31'd0, !we});
            end
            if (we && (n == 5 || n == 6))
                check("bus_wdata", {24'd0, mem_data}, {24'd0, wdata});
            else if (!(!we && (n == 5 || n == 6)))
                check("bus_release", {24'd0, mem_data}, 32'h0000_00FF);
            if (n < 8) @(negedge clk);
        end
        last_rd = exp_rd;
        $display("txn we=%0d addr=%h wdata=%h rd_data=%h", we, addr, wdata, host_if.rd_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accept_at[$];
        logic [7:0] b2b_addr;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        last_rd           = 8'h00;
        reset             = 1'b0;
        host_if.req       = 1'b0;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = 8'h00;
        host_if.req_wdata = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_ready", {31'd0, host_if.ready}, 32'd1);
        check("rst_strobes", {28'd0, mem_seq, mem_wait, mem_ras, mem_cas}, 32'd0);
        check("rst_rd_data", {24'd0, host_if.rd_data}, 32'd0);
        check("rst_pulses", {30'd0, host_if.rd_valid, host_if.wr_done}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_cmd", {31'd0, mem_cmd}, 32'd1);
        check("rst_bus", {24'd0, mem_data}, 32'h0000_00FF);
        reset = 1'b1;

        // Accepted on the very first edge after reset release.
        do_txn(1'b1, 8'h10, 8'hA5, 1'b0);
        do_txn(1'b0, 8'h10, 8'h00, 1'b0);
        do_txn(1'b1, 8'hFF, 8'hFF, 1'b1);
        do_txn(1'b0, 8'hFF, 8'h00, 1'b1);

        // req held high: acceptances every 8 cycles.
        b2b_addr          = 8'($urandom);
        host_if.req       = 1'b1;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = b2b_addr;
        for (int i = 0; i < 24; i++) begin
            if (host_if.ready) accept_at.push_back(i);
            @(negedge clk);
        end
        host_if.req = 1'b0;
        check("b2b_count", accept_at.size(), 3);
        for (int i = 1; i < accept_at.size(); i++)
            check("b2b_period", accept_at[i] - accept_at[i-1], 8);
        repeat (10) @(negedge clk);
        last_rd = ref_mem[b2b_addr];
        check("b2b_rd_data", {24'd0, host_if.rd_data}, {24'd0, last_rd});
        $display("txn back-to-back reads addr=%h acceptances=%0d", b2b_addr, accept_at.size());

        // Reset during RAS of a write aborts it.
        wait_ready();
        host_if.req       = 1'b1;
        host_if.req_we    = 1'b1;
        host_if.req_addr  = 8'h33;
        host_if.req_wdata = ~ref_mem[8'h33];
        @(posedge clk);
        @(negedge clk);
        host_if.req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_ras", {28'd0, mem_seq, mem_wait, mem_ras, mem_cas}, 32'b1010);
        #2 reset = 1'b0;
        #1;
        check("abort_strobes", {28'd0, mem_seq, mem_wait, mem_ras, mem_cas}, 32'd0);
        check("abort_ready", {31'd0, host_if.ready}, 32'd1);
        check("abort_bus", {24'd0, mem_data}, 32'h0000_00FF);
        check("abort_rd_data", {24'd0, host_if.rd_data}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, host_if.wr_done, host_if.rd_valid}, 32'd0);
        end
        reset   = 1'b1;
        last_rd = 8'h00;
        $display("txn write addr=33 aborted by reset");
        do_txn(1'b0, 8'h33, 8'h00, 1'b0);

        // Random traffic over a small address window for read-after-write hits.
        for (int t = 0; t < 40; t++)
            do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                   1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
